window_count_ctrl: RTL and testbench
====================================

Name: window_count_ctrl

Overview:
Sequencer for the shared 19-bit up/down event counter in the sampled-signal path. It converts per-sample polarity strobes into counter up/down commands and frames a fixed window of accepted samples. At each window end it latches the signed count into a result register with a valid/ready handshake, then clears the counter for the next window. It sits between the sample-rate strobe logic and the downstream threshold/decision logic.

Parameters:
CNT_WIDTH, 19, width of counter value and result (two's complement)
WIN_LEN, 200000, accepted samples per window (1 s at 200 kHz)
WIN_CW, 18, width of the sample-index counter; must hold WIN_LEN-1

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  pulse; begin windowing when IDLE
stop  input  1  pulse; abort and return to IDLE
sample_valid  input  1  one-cycle sample strobe
sample_pos  input  1  sample is a positive event (qualified by sample_valid)
sample_neg  input  1  sample is a negative event (qualified by sample_valid)
cnt_value  input  CNT_WIDTH  current counter output
cnt_up  output  1  counter up command, registered
cnt_down  output  1  counter down command, registered
cnt_clear  output  1  counter reset command, registered
result  output  CNT_WIDTH  latched window count, signed
result_valid  output  1  result available
result_ready  input  1  consumer accepts result
busy  output  1  state is not IDLE
sample_drop  output  1  one-cycle pulse: sample_valid arrived outside RUN while busy

Behaviour:
- Reset: state IDLE; all outputs 0, result 0, index 0.
- States: IDLE, RUN, DRAIN, LATCH, CLEAR.
- IDLE: start -> CLEAR. cnt_clear is asserted for one cycle, then the FSM enters RUN with index 0.
- RUN: on sample_valid, the next cycle drives cnt_up = pos & !neg and cnt_down = neg & !pos. Pos and neg together, or neither, is still an accepted sample: index increments, no count change.
- In RUN, when the sample at index WIN_LEN-1 is accepted, go to DRAIN. DRAIN lasts one cycle so the last command lands in the counter.
- LATCH (one cycle): result <= cnt_value, result_valid <= 1. Then CLEAR (cnt_clear one cycle, index <= 0), then RUN.
- Window period: WIN_LEN accepted samples. Latch occurs 3 cycles after the accepting cycle of the last sample.
- A sample_valid in DRAIN, LATCH or CLEAR is not counted and pulses sample_drop the next cycle. Upstream guarantees sample spacing of at least 4 cycles, so this is an error indicator only.
- cnt_up, cnt_down and cnt_clear are never asserted together. Outside the cycle after an accepted RUN sample, cnt_up and cnt_down are 0.
- Handshake: result_valid stays high until a cycle with result_ready=1, then drops the next cycle. result is stable while valid and unaccepted, except on overrun (see feature).
- Overrun: a LATCH while result_valid=1 and not accepted overwrites result and keeps valid high.
- stop, any state: next state IDLE; cnt_clear pulses once; result and result_valid are kept. Any partial window is discarded. stop has priority over start.
- start while busy: ignored.
- Reset mid-window: immediate return to reset values. The counter itself is reset by the shared reset.

Optional Feature:
Macro WINDOW_COUNT_CTRL_OVERRUN_EN.
- Defined: adds output port overrun (1 bit, sticky), set on an overwrite-while-valid LATCH and cleared by reset or start. On overrun, result is NOT overwritten: the old result is held and the new window value is lost.
- Undefined: no port; overwrite semantics as in Behaviour.

Decomposition:
- Shared package holds: the state encoding typedef (5 states, 3 bits), the default CNT_WIDTH/WIN_LEN/WIN_CW constants, and the SAMPLE_GAP_MIN=4 constant.
- The counter stays external, driven by cnt_up/cnt_down, with cnt_clear OR'd into its reset.
- One natural sub-module: window_result_reg (result register + valid/ready + overrun logic).

Test Plan (WIN_LEN=8, WIN_CW=3, counter model attached):
- 8 samples, 5 pos and 3 neg, gap 4 -> result=+2, result_valid rises 3 cycles after the 8th accepting cycle, cnt_clear pulses the next cycle.
- 8 samples all neg -> result=-8 (0x7FFF8 at 19 bits); the next window starts from 0.
- Sample with pos=neg=1 -> counted toward the window, no cnt_up/cnt_down; 8 such samples give result=0.
- Sample_valid injected in the DRAIN cycle -> sample_drop pulses, and the window index does not advance.
- result_ready held 0 across two windows (+3, then -1) -> result=-1 and valid stays 1 with macro off; with macro on, result=+3 and overrun=1.
- stop after 5 samples -> IDLE, busy=0, one cnt_clear pulse, prior result unchanged; reset mid-RUN clears all outputs the next cycle.

Source files
------------

// File: rtl/window_count_ctrl_pkg.sv
// rtl/window_count_ctrl_pkg.sv - shared types and defaults for the window count sequencer
package window_count_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_LATCH = 3'd3,
    ST_CLEAR = 3'd4
  } wcc_state_e;

  localparam int CNT_WIDTH_DEF  = 19;
  localparam int WIN_LEN_DEF    = 200000;
  localparam int WIN_CW_DEF     = 18;
  localparam int SAMPLE_GAP_MIN = 4;

endpackage

// File: rtl/window_count_ctrl_result_reg.sv
// rtl/window_count_ctrl_result_reg.sv - window result register with valid/ready handshake
// WINDOW_COUNT_CTRL_OVERRUN_EN: hold old result on overwrite-while-valid and flag sticky overrun.
module window_result_reg
  import window_count_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 latch_i,
  input  logic [CNT_WIDTH-1:0] cnt_value_i,
  input  logic                 ready_i,
`ifdef WINDOW_COUNT_CTRL_OVERRUN_EN
  input  logic                 clr_overrun_i,
  output logic                 overrun_o,
`endif
  output logic [CNT_WIDTH-1:0] result_o,
  output logic                 valid_o
);

  logic [CNT_WIDTH-1:0] result_q, result_d;
  logic                 valid_q, valid_d;
`ifdef WINDOW_COUNT_CTRL_OVERRUN_EN
  logic                 overrun_q, overrun_d;
`endif

  always_comb begin
    result_d = result_q;
    valid_d  = valid_q;
`ifdef WINDOW_COUNT_CTRL_OVERRUN_EN
    overrun_d = overrun_q;
    if (clr_overrun_i) overrun_d = 1'b0;
`endif
    if (valid_q && ready_i) valid_d = 1'b0;
    if (latch_i) begin
`ifdef WINDOW_COUNT_CTRL_OVERRUN_EN
      // An unaccepted result wins over the new window value.
      if (valid_q && !ready_i) begin
        overrun_d = 1'b1;
      end else begin
        result_d = cnt_value_i;
        valid_d  = 1'b1;
      end
`else
      result_d = cnt_value_i;
      valid_d  = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
      valid_q  <= 1'b0;
`ifdef WINDOW_COUNT_CTRL_OVERRUN_EN
      overrun_q <= 1'b0;
`endif
    end else begin
      result_q <= result_d;
      valid_q  <= valid_d;
`ifdef WINDOW_COUNT_CTRL_OVERRUN_EN
      overrun_q <= overrun_d;
`endif
    end
  end

  assign result_o = result_q;
  assign valid_o  = valid_q;
`ifdef WINDOW_COUNT_CTRL_OVERRUN_EN
  assign overrun_o = overrun_q;
`endif

endmodule

// File: rtl/window_count_ctrl.sv
// rtl/window_count_ctrl.sv - frames fixed sample windows and drives the external up/down counter
// WINDOW_COUNT_CTRL_OVERRUN_EN adds the sticky overrun output.
module window_count_ctrl
  import window_count_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF,
  parameter int WIN_LEN   = WIN_LEN_DEF,
  parameter int WIN_CW    = WIN_CW_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 sample_valid,
  input  logic                 sample_pos,
  input  logic                 sample_neg,
  input  logic [CNT_WIDTH-1:0] cnt_value,
  output logic                 cnt_up,
  output logic                 cnt_down,
  output logic                 cnt_clear,
  output logic [CNT_WIDTH-1:0] result,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic                 busy,
  output logic                 sample_drop
`ifdef WINDOW_COUNT_CTRL_OVERRUN_EN
  ,output logic                overrun
`endif
);

  wcc_state_e        state_q;
  logic [WIN_CW-1:0] idx_q;
  logic              cnt_up_q, cnt_down_q, cnt_clear_q, sample_drop_q;
  logic              in_gap;

  assign in_gap = (state_q == ST_DRAIN) || (state_q == ST_LATCH) || (state_q == ST_CLEAR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      cnt_up_q      <= 1'b0;
      cnt_down_q    <= 1'b0;
      cnt_clear_q   <= 1'b0;
      sample_drop_q <= 1'b0;
    end else begin
      cnt_up_q      <= 1'b0;
      cnt_down_q    <= 1'b0;
      cnt_clear_q   <= 1'b0;
      sample_drop_q <= sample_valid && in_gap;
      if (stop) begin
        state_q     <= ST_IDLE;
        idx_q       <= '0;
        cnt_clear_q <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: if (start) state_q <= ST_CLEAR;
          ST_RUN: begin
            if (sample_valid) begin
              cnt_up_q   <= sample_pos && !sample_neg;
              cnt_down_q <= sample_neg && !sample_pos;
              idx_q      <= idx_q + WIN_CW'(1);
              if (idx_q == WIN_CW'(WIN_LEN - 1)) state_q <= ST_DRAIN;
            end
          end
          // DRAIN gives the last up/down command one cycle to land in the counter.
          ST_DRAIN: state_q <= ST_LATCH;
          ST_LATCH: state_q <= ST_CLEAR;
          ST_CLEAR: begin
            cnt_clear_q <= 1'b1;
            idx_q       <= '0;
            state_q     <= ST_RUN;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  window_result_reg #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_result (
    .clk           (clk),
    .reset         (reset),
    .latch_i       ((state_q == ST_LATCH) && !stop),
    .cnt_value_i   (cnt_value),
    .ready_i       (result_ready),
`ifdef WINDOW_COUNT_CTRL_OVERRUN_EN
    .clr_overrun_i ((state_q == ST_IDLE) && start && !stop),
    .overrun_o     (overrun),
`endif
    .result_o      (result),
    .valid_o       (result_valid)
  );

  assign cnt_up      = cnt_up_q;
  assign cnt_down    = cnt_down_q;
  assign cnt_clear   = cnt_clear_q;
  assign sample_drop = sample_drop_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_window_count_ctrl.sv
// tb/tb_window_count_ctrl.sv - directed and randomized check of window_count_ctrl against a timeline model
module tb_window_count_ctrl;

  localparam int CW  = 19;
  localparam int WL  = 8;
  localparam int WCW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1, start = 1'b0, stop = 1'b0;
  logic          sample_valid = 1'b0, sample_pos = 1'b0, sample_neg = 1'b0;
  logic          result_ready = 1'b0;
  logic [CW-1:0] cnt_q = '0;
  logic [CW-1:0] cnt_value;
  logic          cnt_up, cnt_down, cnt_clear, result_valid, busy, sample_drop;
  logic [CW-1:0] result;
`ifdef WINDOW_COUNT_CTRL_OVERRUN_EN
  logic          overrun;
`endif

  window_count_ctrl #(.CNT_WIDTH(CW), .WIN_LEN(WL), .WIN_CW(WCW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .sample_valid (sample_valid),
    .sample_pos   (sample_pos),
    .sample_neg   (sample_neg),
    .cnt_value    (cnt_value),
    .cnt_up       (cnt_up),
    .cnt_down     (cnt_down),
    .cnt_clear    (cnt_clear),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .busy         (busy),
    .sample_drop  (sample_drop)
`ifdef WINDOW_COUNT_CTRL_OVERRUN_EN
    ,.overrun     (overrun)
`endif
  );

  always #5 clk = ~clk;

  // External event counter, with cnt_clear OR'd into its reset.
  always @(posedge clk) begin
    if (reset || cnt_clear) cnt_q <= '0;
    else if (cnt_up)        cnt_q <= cnt_q + 1'b1;
    else if (cnt_down)      cnt_q <= cnt_q - 1'b1;
  end
  assign cnt_value = cnt_q;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, got, exp);
    end
  endtask

  // Timeline model: events are scheduled at absolute cycle numbers.
  bit            up_s[int], dn_s[int], clr_s[int], drop_s[int];
  bit            m_busy = 0, m_valid = 0, m_ovr = 0;
  logic [CW-1:0] m_res = '0;
  int            n_acc = 0, win_sum = 0, latch_c = -1, latch_val = 0, accept_from = 0;
  bit            nbusy, nv, novr;
  logic [CW-1:0] nres;

  function automatic void purge(input int k);
    if (up_s.exists(k))   up_s.delete(k);
    if (dn_s.exists(k))   dn_s.delete(k);
    if (clr_s.exists(k))  clr_s.delete(k);
    if (drop_s.exists(k)) drop_s.delete(k);
  endfunction

  always @(negedge clk) begin
    int c;
    c = cyc;
    if (c >= 1) begin
      chk("busy", busy, m_busy);
      chk("result", result, m_res);
      chk("result_valid", result_valid, m_valid);
      chk("cnt_up", cnt_up, up_s.exists(c) ? up_s[c] : 1'b0);
      chk("cnt_down", cnt_down, dn_s.exists(c) ? dn_s[c] : 1'b0);
      chk("cnt_clear", cnt_clear, clr_s.exists(c) ? clr_s[c] : 1'b0);
      chk("sample_drop", sample_drop, drop_s.exists(c) ? drop_s[c] : 1'b0);
      chk("cmd_exclusive", ($countones({cnt_up, cnt_down, cnt_clear}) <= 1), 1);
`ifdef WINDOW_COUNT_CTRL_OVERRUN_EN
      chk("overrun", overrun, m_ovr);
`endif
    end
    if (reset) begin
      up_s.delete(); dn_s.delete(); clr_s.delete(); drop_s.delete();
      m_busy = 0; m_valid = 0; m_ovr = 0; m_res = '0;
      n_acc = 0; win_sum = 0; latch_c = -1; accept_from = 0;
    end else begin
      nbusy = m_busy; nv = m_valid; novr = m_ovr; nres = m_res;
      if (m_valid && result_ready) nv = 0;
      if (stop) begin
        for (int k = c + 1; k <= c + 6; k++) purge(k);
        clr_s[c+1] = 1;
        nbusy = 0; n_acc = 0; win_sum = 0; latch_c = -1;
      end else begin
        if (c == latch_c) begin
`ifdef WINDOW_COUNT_CTRL_OVERRUN_EN
          if (m_valid && !result_ready) novr = 1;
          else begin nres = latch_val[CW-1:0]; nv = 1; end
`else
          nres = latch_val[CW-1:0]; nv = 1;
`endif
          latch_c = -1;
        end
        if (!m_busy) begin
          if (start) begin
            nbusy = 1; accept_from = c + 2; clr_s[c+2] = 1;
            n_acc = 0; win_sum = 0; novr = 0;
          end
        end else if (sample_valid) begin
          if (c >= accept_from) begin
            up_s[c+1] = sample_pos && !sample_neg;
            dn_s[c+1] = sample_neg && !sample_pos;
            win_sum += (sample_pos && !sample_neg) ? 1 : ((sample_neg && !sample_pos) ? -1 : 0);
            n_acc++;
            if (n_acc == WL) begin
              latch_c = c + 2; latch_val = win_sum;
              n_acc = 0; win_sum = 0;
              accept_from = c + 4; clr_s[c+4] = 1;
            end
          end else begin
            drop_s[c+1] = 1;
          end
        end
      end
      m_busy = nbusy; m_valid = nv; m_ovr = novr; m_res = nres;
    end
  end

  int  rise_cyc = -1, clr_cyc = -1, drop_cyc = -1, clr_count = 0;
  bit  prev_valid = 0;
  always @(negedge clk) begin
    if (result_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = result_valid;
    if (cnt_clear) begin clr_cyc = cyc; clr_count++; end
    if (sample_drop) drop_cyc = cyc;
  end

  bit rand_ready = 0;
  int acc_cyc = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) result_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input bit p, input bit n, input int gap);
    sample_valid = 1; sample_pos = p; sample_neg = n; acc_cyc = cyc;
    tick();
    sample_valid = 0; sample_pos = 0; sample_neg = 0;
    repeat (gap - 1) tick();
  endtask

  task automatic do_start();
    start = 1; tick(); start = 0; tick();
  endtask

  task automatic accept();
    result_ready = 1; tick(); result_ready = 0;
  endtask

  logic [CW-1:0] exp5;
  int            r;
  bit            did_reset;

  initial begin
    int gap = window_count_ctrl_pkg::SAMPLE_GAP_MIN;
    repeat (3) tick();
    reset = 0;
    chk("rst_result", result, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", result_valid, 0);

    // 5 pos, 3 neg -> +2
    do_start();
    repeat (5) send(1, 0, gap);
    repeat (3) send(0, 1, gap);
    tick();
    chk("w1_result", result, 19'd2);
    chk("w1_model", m_res, 19'd2);
    chk("w1_valid_latency", rise_cyc - acc_cyc, 3);
    chk("w1_clear_after_valid", clr_cyc - rise_cyc, 1);

    // all neg -> -8
    accept();
    repeat (8) send(0, 1, gap);
    tick();
    chk("w2_result", result, 19'h7FFF8);
    chk("w2_valid_latency", rise_cyc - acc_cyc, 3);

    // pos and neg together -> counted, no change
    accept();
    repeat (8) send(1, 1, gap);
    tick();
    chk("w3_result", result, 19'd0);
    chk("w3_valid_latency", rise_cyc - acc_cyc, 3);

    // sample injected into DRAIN
    accept();
    repeat (7) send(1, 0, gap);
    sample_valid = 1; sample_pos = 1; acc_cyc = cyc; tick();
    sample_valid = 1; sample_pos = 1; tick();
    sample_valid = 0; sample_pos = 0;
    repeat (3) tick();
    chk("w4_drop_cycle", drop_cyc - acc_cyc, 2);
    chk("w4_result", result, 19'd8);
    accept();
    repeat (8) send(1, 0, gap);
    tick();
    chk("w5_result", result, 19'd8);
    chk("w5_valid_latency", rise_cyc - acc_cyc, 3);

    // two windows with no acceptance: +3 then -1
    accept();
    repeat (5) send(1, 0, gap);
    repeat (2) send(0, 1, gap);
    send(1, 1, gap);
    repeat (3) send(1, 0, gap);
    repeat (4) send(0, 1, gap);
    send(0, 0, gap);
    tick();
`ifdef WINDOW_COUNT_CTRL_OVERRUN_EN
    exp5 = 19'd3;
    chk("ovr_flag", overrun, 1);
`else
    exp5 = 19'h7FFFF;
`endif
    chk("ovr_result", result, exp5);
    chk("ovr_valid", result_valid, 1);

    // stop mid-window
    accept();
    tick();
    repeat (5) send(1, 0, gap);
    clr_count = 0;
    stop = 1; tick(); stop = 0;
    repeat (3) tick();
    chk("stop_busy", busy, 0);
    chk("stop_clear_pulses", clr_count, 1);
    chk("stop_result_kept", result, exp5);
    chk("stop_valid", result_valid, 0);

    // reset mid-RUN
    do_start();
    repeat (3) send(1, 0, gap);
    reset = 1; tick(); reset = 0;
    chk("mrst_result", result, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_cmds", {cnt_up, cnt_down, cnt_clear, sample_drop, result_valid}, 0);
    tick();

    // randomized traffic
    rand_ready = 1;
    did_reset = 0;
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 99);
      if (!m_busy) begin
        start = 1; tick(); start = 0;
      end else if (r < 2) begin
        stop = 1; tick(); stop = 0;
      end else if (r < 4) begin
        start = 1; tick(); start = 0;
      end else if (r == 4 && !did_reset) begin
        did_reset = 1;
        reset = 1; tick(); reset = 0;
      end else if (r < 10) begin
        send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 3));
      end else begin
        send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(4, 7));
      end
    end
    rand_ready = 0;
    repeat (8) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
